block_bbox_tracker: RTL
=======================

# block_bbox_tracker

Downstream stage of the moving-block video generator: consumes the `video_vs`/`video_de`/`video_rgb` stream on `pixel_clk` and locates pixels matching a key colour (the moving block). Once per frame it publishes the block's bounding box, pixel count and frame-to-frame centre displacement. It is the first measurement stage feeding flow-estimation logic, self-checked against the known block trajectory.

## Interface
- `H_DISP`, 1920, active pixels per line; wider lines are clipped.
- `V_DISP`, 1080, active lines per frame; extra lines are clipped.
- `KEY_COLOR`, 24'hffc0cb, RGB888 colour to track.
- `KEY_TOL`, 8'd0, per-channel tolerance; match when |ch − key_ch| ≤ KEY_TOL for R, G and B.
- `VS_POL`, 1'b1, active level of `video_vs`.
- `pixel_clk`, in, 1, sole clock; all logic on its rising edge.
- `sys_rst_n`, in, 1, asynchronous active-low reset.
- `video_vs`, in, 1, vertical sync, level per VS_POL.
- `video_de`, in, 1, active-video qualifier, high = valid pixel.
- `video_rgb`, in, 24, pixel {R[23:16], G[15:8], B[7:0]}, valid when `video_de`=1.
- `o_valid`, out, 1, one-cycle pulse: result outputs updated.
- `o_found`, out, 1, ≥1 matching pixel in the reported frame.
- `o_xmin` / `o_xmax`, out, 11 each, bounding-box columns (inclusive).
- `o_ymin` / `o_ymax`, out, 11 each, bounding-box rows (inclusive).
- `o_count`, out, 22, matching pixels in frame, saturates at 22'h3fffff.
- `o_dx` / `o_dy`, out, 12 signed each, centre displacement versus the previous reported frame.
- `o_motion_ok`, out, 1, `o_dx`/`o_dy` meaningful.

## Operation
- **Position counters**
  - x increments on each `video_de`=1 cycle and clears to 0 on the cycle after a `video_de` falling edge.
  - y increments on each `video_de` falling edge and clears to 0 on the vs active edge.
  - Counters saturate at 2047.
  - Pixels with x ≥ H_DISP or y ≥ V_DISP are never matches.
- **Stage 1 (registered):** match flag = de & in-range & colour match, plus x and y.
- **Stage 2 (accumulate), on a match:**
  - First match of frame: load xmin = xmax = x and ymin = ymax = y.
  - Otherwise: min/max update.
  - count += 1, saturating.
- **Frame end**
  - Trigger is the vs active edge: `video_vs` sampled at VS_POL while previous sample was ¬VS_POL.
  - The pipeline is drained because `video_de` is low during blanking.
- **State machine:** IDLE → ARMED → RUN.
  - IDLE (after reset): the first vs edge clears accumulators and goes to ARMED, with no publish. The partial frame after reset is discarded.
  - ARMED and RUN: every vs edge publishes, then clears accumulators. ARMED → RUN after the first publish.
- **Publish**
  - `o_found` = (count ≠ 0).
  - When found: box and count are latched from the accumulators. When not found: box = 0 and count = 0.
  - Centre: cx = (xmin + xmax) >> 1, cy = (ymin + ymax) >> 1, each 11-bit unsigned.
  - `o_motion_ok` = found now & found at previous publish & state was RUN.
  - When `o_motion_ok`: `o_dx` = cx − cx_prev and `o_dy` = cy − cy_prev, zero-extended to 12 bits before subtracting. Otherwise both are 0.
  - cx_prev/cy_prev/found_prev update on every publish.
- Result outputs hold between publishes.

## Timing
- All outputs reset to 0; state resets to IDLE.
- Reset is asynchronous. Deassertion mid-frame restarts at IDLE; the next vs edge only arms.
- Vs edge detected in cycle N (first sampled active) → accumulators read and cleared in N+1 → outputs valid and `o_valid`=1 in N+2.
- `o_valid` is high exactly 1 cycle per published frame.
- Pixel-to-accumulator latency is 2 cycles. A match in the last active cycle before the vs edge must be counted, with a minimum of 2 blanking cycles between last de and the vs edge.
- Vs held active for many cycles produces one publish only. Vs is ignored while de=1.
- A frame with no de cycles publishes found=0 and count=0.

## Test plan
- H_DISP=64, V_DISP=32, KEY_TOL=0; 8×8 key block at x=10..17, y=4..11 on a white background, 3 frames → first vs edge produces no `o_valid`. Each later frame gives `o_valid` 2 cycles after vs, box (10,17,4,11), count=64, found=1. Frame 3 has `o_motion_ok`=1 and dx=dy=0.
- Block moves +3 x and −2 y per frame → dx=+3 (12'h003), dy=−2 (12'hffe), `o_motion_ok`=1.
- Frame with no key pixels between two frames with the block → found=0, box/count=0, `o_motion_ok`=0 for that frame and for the next frame.
- KEY_TOL=2: pixels at key±2 per channel are counted; key+3 in any one channel is rejected.
- Single key pixel at x=63, y=31 plus de extended to 70 pixels on one line → box (63,63,31,31), count=1. Key pixels at x≥64 are ignored.
- Pulse `sys_rst_n` low mid-frame → all outputs 0 immediately. The next vs edge produces no publish; the following vs edge publishes with `o_motion_ok`=0.

Source files
------------

// File: rtl/block_bbox_tracker.sv
// Key-colour bounding-box tracker: finds pixels matching KEY_COLOR in a video stream and
// publishes the box, pixel count and frame-to-frame centre displacement on every vs edge.
module block_bbox_tracker #(
  parameter int unsigned H_DISP    = 1920,
  parameter int unsigned V_DISP    = 1080,
  parameter logic [23:0] KEY_COLOR = 24'hffc0cb,
  parameter logic [7:0]  KEY_TOL   = 8'd0,
  parameter logic        VS_POL    = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               sys_rst_n,
  input  logic               video_vs,
  input  logic               video_de,
  input  logic [23:0]        video_rgb,
  output logic               o_valid,
  output logic               o_found,
  output logic [10:0]        o_xmin,
  output logic [10:0]        o_xmax,
  output logic [10:0]        o_ymin,
  output logic [10:0]        o_ymax,
  output logic [21:0]        o_count,
  output logic signed [11:0] o_dx,
  output logic signed [11:0] o_dy,
  output logic               o_motion_ok
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic [10:0] POS_MAX = 11'h7ff;
  localparam logic [21:0] CNT_MAX = 22'h3fffff;

  function automatic logic chan_match(input logic [7:0] chan, input logic [7:0] key);
    logic [7:0] diff;
    diff = (chan >= key) ? (chan - key) : (key - chan);
    return diff <= KEY_TOL;
  endfunction

  state_t state, state_next;

  logic        vs_act, vs_act_q, de_q, de_fall, vs_edge, vs_edge_q;
  logic [10:0] x_cnt, y_cnt;
  logic        in_range, color_ok;
  logic        s1_match;
  logic [10:0] s1_x, s1_y;
  logic        clear_acc, snap_en;
  logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [21:0] acc_count;
  logic        snap_pend, snap_found, snap_run;
  logic [10:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;
  logic [21:0] snap_count;
  logic        found_prev;
  logic [10:0] cx_prev, cy_prev;
  logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic [11:0] sum_x, sum_y, dx_calc, dy_calc;
  logic [10:0] cx, cy;
  logic        motion_ok;

  // A vs edge is only honoured during blanking so a mid-line vs glitch cannot end the frame.
  assign vs_act  = (video_vs == VS_POL);
  assign de_fall = de_q & ~video_de;
  assign vs_edge = vs_act & ~vs_act_q & ~video_de;

  assign in_range = (32'(x_cnt) < H_DISP) && (32'(y_cnt) < V_DISP);
  assign color_ok = chan_match(video_rgb[23:16], KEY_COLOR[23:16]) &
                    chan_match(video_rgb[15:8],  KEY_COLOR[15:8])  &
                    chan_match(video_rgb[7:0],   KEY_COLOR[7:0]);

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_act_q  <= 1'b0;
      de_q      <= 1'b0;
      vs_edge_q <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      s1_match  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
    end else begin
      vs_act_q  <= vs_act;
      de_q      <= video_de;
      vs_edge_q <= vs_edge;
      if (video_de) begin
        if (x_cnt != POS_MAX) x_cnt <= x_cnt + 11'd1;
      end else if (de_fall) begin
        x_cnt <= '0;
      end
      if (vs_edge) y_cnt <= '0;
      else if (de_fall && y_cnt != POS_MAX) y_cnt <= y_cnt + 11'd1;
      s1_match <= video_de & in_range & color_ok;
      s1_x     <= x_cnt;
      s1_y     <= y_cnt;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  // The first vs edge after reset only arms: the partial frame before it is discarded.
  always_comb begin
    state_next = state;
    clear_acc  = 1'b0;
    snap_en    = 1'b0;
    if (vs_edge_q) begin
      clear_acc = 1'b1;
      case (state)
        IDLE:    state_next = ARMED;
        ARMED: begin
          snap_en    = 1'b1;
          state_next = RUN;
        end
        RUN:     snap_en = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_xmin  <= '0;
      acc_xmax  <= '0;
      acc_ymin  <= '0;
      acc_ymax  <= '0;
      acc_count <= '0;
    end else if (clear_acc) begin
      acc_xmin  <= '0;
      acc_xmax  <= '0;
      acc_ymin  <= '0;
      acc_ymax  <= '0;
      acc_count <= '0;
    end else if (s1_match) begin
      if (acc_count == '0) begin
        acc_xmin <= s1_x;
        acc_xmax <= s1_x;
        acc_ymin <= s1_y;
        acc_ymax <= s1_y;
      end else begin
        if (s1_x < acc_xmin) acc_xmin <= s1_x;
        if (s1_x > acc_xmax) acc_xmax <= s1_x;
        if (s1_y < acc_ymin) acc_ymin <= s1_y;
        if (s1_y > acc_ymax) acc_ymax <= s1_y;
      end
      if (acc_count != CNT_MAX) acc_count <= acc_count + 22'd1;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap_pend  <= 1'b0;
      snap_found <= 1'b0;
      snap_run   <= 1'b0;
      snap_xmin  <= '0;
      snap_xmax  <= '0;
      snap_ymin  <= '0;
      snap_ymax  <= '0;
      snap_count <= '0;
    end else begin
      snap_pend <= snap_en;
      if (snap_en) begin
        snap_found <= (acc_count != '0);
        snap_run   <= (state == RUN);
        snap_xmin  <= acc_xmin;
        snap_xmax  <= acc_xmax;
        snap_ymin  <= acc_ymin;
        snap_ymax  <= acc_ymax;
        snap_count <= acc_count;
      end
    end
  end

  // Centre uses a 12-bit sum so xmin+xmax never wraps before halving.
  always_comb begin
    box_xmin = '0;
    box_xmax = '0;
    box_ymin = '0;
    box_ymax = '0;
    if (snap_found) begin
      box_xmin = snap_xmin;
      box_xmax = snap_xmax;
      box_ymin = snap_ymin;
      box_ymax = snap_ymax;
    end
    sum_x     = {1'b0, box_xmin} + {1'b0, box_xmax};
    sum_y     = {1'b0, box_ymin} + {1'b0, box_ymax};
    cx        = sum_x[11:1];
    cy        = sum_y[11:1];
    motion_ok = snap_found & found_prev & snap_run;
    dx_calc   = '0;
    dy_calc   = '0;
    if (motion_ok) begin
      dx_calc = {1'b0, cx} - {1'b0, cx_prev};
      dy_calc = {1'b0, cy} - {1'b0, cy_prev};
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      o_valid     <= 1'b0;
      o_found     <= 1'b0;
      o_xmin      <= '0;
      o_xmax      <= '0;
      o_ymin      <= '0;
      o_ymax      <= '0;
      o_count     <= '0;
      o_dx        <= '0;
      o_dy        <= '0;
      o_motion_ok <= 1'b0;
      found_prev  <= 1'b0;
      cx_prev     <= '0;
      cy_prev     <= '0;
    end else begin
      o_valid <= snap_pend;
      if (snap_pend) begin
        o_found     <= snap_found;
        o_xmin      <= box_xmin;
        o_xmax      <= box_xmax;
        o_ymin      <= box_ymin;
        o_ymax      <= box_ymax;
        o_count     <= snap_found ? snap_count : '0;
        o_dx        <= dx_calc;
        o_dy        <= dy_calc;
        o_motion_ok <= motion_ok;
        found_prev  <= snap_found;
        cx_prev     <= cx;
        cy_prev     <= cy;
      end
    end
  end

endmodule
